// File: rtl/fifo_ram_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : fifo_ram_pkg
//  Description : Shared types and ring-address helpers for the FIFO-to-RAM
//                writer and the RAM-to-FIFO reader stages.
//  Revision    : 1.0 - initial release
// ============================================================================
package fifo_ram_pkg;

  // Reader sequencing states; width fixed so encodings are stable.
  typedef enum logic [1:0] {
    RD_IDLE  = 2'd0,
    RD_ISSUE = 2'd1,
    RD_WAIT  = 2'd2,
    RD_PUSH  = 2'd3
  } read_state_e;

  // Helpers work on a wide address; callers truncate to their own width.
  localparam int unsigned c_RING_ADDR_W = 32;
  typedef logic [c_RING_ADDR_W-1:0] ring_addr_t;

  // Next address in ring order, wrapping from the upper to the lower bound.
  function automatic ring_addr_t ring_next_addr(input ring_addr_t addr,
                                                input ring_addr_t lower,
                                                input ring_addr_t upper);
    ring_addr_t r;
    if (addr == upper) r = lower;
    else               r = addr + ring_addr_t'(1);
    return r;
  endfunction

  // Force an externally supplied address into the ring window.
  function automatic ring_addr_t ring_clamp_addr(input ring_addr_t addr,
                                                 input ring_addr_t lower,
                                                 input ring_addr_t upper);
    ring_addr_t r;
    if (addr > upper)      r = lower;
    else if (addr < lower) r = upper;
    else                   r = addr;
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ring_address_pointer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : ring_address_pointer
//  Description : Ring pointer register with wrap-increment, clamped load and
//                occupancy (Level/Empty) relative to a peer pointer.
//  Revision    : 1.0 - initial release
// ============================================================================
module ring_address_pointer
  import fifo_ram_pkg::*;
#(
  parameter int AddressWidth = 8,
  parameter int LowerBound   = 0,
  parameter int UpperBound   = 2**AddressWidth-1
) (
  input  logic                    Clock,
  input  logic                    Reset_n,
  input  logic                    i_advance,
  input  logic                    i_load,
  input  logic [AddressWidth-1:0] i_load_value,
  input  logic [AddressWidth-1:0] i_peer_pointer,
  output logic [AddressWidth-1:0] o_pointer,
  output logic [AddressWidth:0]   o_level,
  output logic                    o_empty
);

  localparam int                      c_DEPTH_I = UpperBound - LowerBound + 1;
  localparam logic [AddressWidth:0]   c_DEPTH   = c_DEPTH_I[AddressWidth:0];
  localparam logic [AddressWidth-1:0] c_LOWER   = LowerBound[AddressWidth-1:0];

  logic [AddressWidth-1:0] r_pointer;
  logic [AddressWidth-1:0] w_next;
  logic [AddressWidth-1:0] w_clamped;
  logic [AddressWidth:0]   w_peer_ext;
  logic [AddressWidth:0]   w_ptr_ext;

  assign w_next    = AddressWidth'(ring_next_addr(ring_addr_t'(r_pointer),
                                                  ring_addr_t'(LowerBound),
                                                  ring_addr_t'(UpperBound)));
  assign w_clamped = AddressWidth'(ring_clamp_addr(ring_addr_t'(i_load_value),
                                                   ring_addr_t'(LowerBound),
                                                   ring_addr_t'(UpperBound)));

  // Pointer register: a load beats an advance, reset parks at the ring start.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n)       r_pointer <= c_LOWER;
    else if (i_load)    r_pointer <= w_clamped;
    else if (i_advance) r_pointer <= w_next;
  end

  // Words between this pointer and the peer, modulo the ring depth.
  always_comb begin
    w_peer_ext = {1'b0, i_peer_pointer};
    w_ptr_ext  = {1'b0, r_pointer};
    if (w_peer_ext >= w_ptr_ext) o_level = w_peer_ext - w_ptr_ext;
    else                         o_level = w_peer_ext + c_DEPTH - w_ptr_ext;
  end

  assign o_pointer = r_pointer;
  assign o_empty   = (r_pointer == i_peer_pointer);

endmodule
`default_nettype wire

// File: rtl/block_ram_to_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : block_ram_to_fifo
//  Description : Drains a block-RAM ring buffer through RAM port B into the
//                write port of an output FIFO, one word per read sequence.
//  Revision    : 1.0 - initial release
// ============================================================================
module block_ram_to_fifo
  import fifo_ram_pkg::*;
#(
  parameter int DataWidth    = 8,
  parameter int AddressWidth = 8,
  parameter int LowerBound   = 0,
  parameter int UpperBound   = 2**AddressWidth-1,
  parameter int ReadLatency  = 1
) (
  input  logic                    Clock,
  input  logic                    Reset_n,
  input  logic [AddressWidth-1:0] WritePointer,
  input  logic                    SetReadPointer,
  input  logic [AddressWidth-1:0] ReadPointerIn,
  output logic [AddressWidth-1:0] ReadPointer,
  output logic [AddressWidth:0]   Level,
  output logic                    Empty,
  output logic                    RAM_clkb,
  output logic                    RAM_enb,
  output logic [AddressWidth-1:0] RAM_addrb,
  input  logic [DataWidth-1:0]    RAM_doutb,
  output logic                    FIFO_wr_clk,
  output logic                    FIFO_wr_en,
  output logic [DataWidth-1:0]    FIFO_din,
  input  logic                    FIFO_full
);

  // Last value of the wait counter before the RAM data is valid.
  localparam logic [1:0] c_WAIT_LAST = 2'(ReadLatency - 1);

  read_state_e          r_state;
  read_state_e          w_next_state;
  logic [1:0]           r_wait_cnt;
  logic [DataWidth-1:0] r_holding;
  logic                 w_wait_done;
  logic                 w_load;
  logic                 w_advance;
  logic                 w_empty;

  assign w_wait_done = (r_wait_cnt == c_WAIT_LAST);
  // Pointer loads and new reads are only considered while idle.
  assign w_load      = (r_state == RD_IDLE) && SetReadPointer;
  assign w_advance   = (r_state == RD_PUSH) && !FIFO_full;

  ring_address_pointer #(
    .AddressWidth (AddressWidth),
    .LowerBound   (LowerBound),
    .UpperBound   (UpperBound)
  ) u_read_pointer (
    .Clock          (Clock),
    .Reset_n        (Reset_n),
    .i_advance      (w_advance),
    .i_load         (w_load),
    .i_load_value   (ReadPointerIn),
    .i_peer_pointer (WritePointer),
    .o_pointer      (ReadPointer),
    .o_level        (Level),
    .o_empty        (w_empty)
  );

  // State register.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) r_state <= RD_IDLE;
    else          r_state <= w_next_state;
  end

  // Next-state logic: pointer load takes priority over starting a read.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      RD_IDLE:  if (!SetReadPointer && !w_empty) w_next_state = RD_ISSUE;
      RD_ISSUE: w_next_state = RD_WAIT;
      RD_WAIT:  if (w_wait_done) w_next_state = RD_PUSH;
      RD_PUSH:  if (!FIFO_full) w_next_state = RD_IDLE;
      default:  w_next_state = RD_IDLE;
    endcase
  end

  // Count read-latency cycles and capture RAM data on the last one.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      r_wait_cnt <= 2'd0;
      r_holding  <= '0;
    end else if (r_state == RD_WAIT) begin
      if (w_wait_done) begin
        r_wait_cnt <= 2'd0;
        r_holding  <= RAM_doutb;
      end else begin
        r_wait_cnt <= r_wait_cnt + 2'd1;
      end
    end
  end

  // Moore-decoded strobes; the FIFO strobe is gated by backpressure.
  always_comb begin
    RAM_enb    = (r_state == RD_ISSUE);
    FIFO_wr_en = (r_state == RD_PUSH) && !FIFO_full;
  end

  assign FIFO_din    = r_holding;
  assign RAM_addrb   = ReadPointer;
  assign Empty       = w_empty;
  assign RAM_clkb    = Clock;
  assign FIFO_wr_clk = Clock;

endmodule
`default_nettype wire

// File: tb/tb_block_ram_to_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_block_ram_to_fifo
//  Description : Self-checking bench; instance A uses ring [0..7] with a
//                1-cycle RAM, instance B uses ring [2..7] with a 2-cycle RAM.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_block_ram_to_fifo;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   tests = 0;
  int   failed = 0;
  int   cyc = 0;

  logic [7:0] wpA, rpinA, rpA, addrbA, dinA;
  logic [7:0] doutA = '0;
  logic       setA, emptyA, clkbA, enbA, fclkA, wrenA, fullA;
  logic [8:0] levelA;
  logic [7:0] wpB, rpinB, rpB, addrbB, dinB;
  logic [7:0] doutB = '0;
  logic [7:0] pipeB = '0;
  logic       setB, emptyB, clkbB, enbB, fclkB, wrenB, fullB;
  logic [8:0] levelB;

  logic [7:0] memA [256];
  logic [7:0] memB [256];
  logic [7:0] gotA [$];
  logic [7:0] gotB [$];
  int         gotA_t [$];
  int         gotB_t [$];
  int         enbA_cnt = 0;
  int         enbB_cnt = 0;

  int         t0, n, idxA, idxB, refA, refB, v, e, enb0;
  logic [7:0] expd [8];

  block_ram_to_fifo #(.DataWidth(8), .AddressWidth(8), .LowerBound(0),
                      .UpperBound(7), .ReadLatency(1)) dut_a (
    .Clock(clk), .Reset_n(rst_n), .WritePointer(wpA), .SetReadPointer(setA),
    .ReadPointerIn(rpinA), .ReadPointer(rpA), .Level(levelA), .Empty(emptyA),
    .RAM_clkb(clkbA), .RAM_enb(enbA), .RAM_addrb(addrbA), .RAM_doutb(doutA),
    .FIFO_wr_clk(fclkA), .FIFO_wr_en(wrenA), .FIFO_din(dinA), .FIFO_full(fullA));

  block_ram_to_fifo #(.DataWidth(8), .AddressWidth(8), .LowerBound(2),
                      .UpperBound(7), .ReadLatency(2)) dut_b (
    .Clock(clk), .Reset_n(rst_n), .WritePointer(wpB), .SetReadPointer(setB),
    .ReadPointerIn(rpinB), .ReadPointer(rpB), .Level(levelB), .Empty(emptyB),
    .RAM_clkb(clkbB), .RAM_enb(enbB), .RAM_addrb(addrbB), .RAM_doutb(doutB),
    .FIFO_wr_clk(fclkB), .FIFO_wr_en(wrenB), .FIFO_din(dinB), .FIFO_full(fullB));

  // RAM port-B models: A registers once, B adds an output register.
  always @(posedge clk) begin
    if (enbA) doutA <= memA[addrbA];
    if (enbB) pipeB <= memB[addrbB];
    doutB <= pipeB;
  end

  // FIFO-side monitor: record every accepted write with its edge index.
  always @(posedge clk) begin
    if (wrenA) begin gotA.push_back(dinA); gotA_t.push_back(cyc); end
    if (wrenB) begin gotB.push_back(dinB); gotB_t.push_back(cyc); end
    if (enbA) enbA_cnt++;
    if (enbB) enbB_cnt++;
    cyc++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_a(input int cnt, input int limit, input bit bp);
    int k = 0;
    while (gotA.size() < cnt && k < limit) begin
      fullA = bp ? ($urandom_range(0, 2) == 0) : 1'b0;
      @(negedge clk);
      k++;
    end
    fullA = 1'b0;
    check("timeout_a", 32'(gotA.size() >= cnt), 32'd1);
  endtask

  task automatic wait_b(input int cnt, input int limit, input bit bp);
    int k = 0;
    while (gotB.size() < cnt && k < limit) begin
      fullB = bp ? ($urandom_range(0, 2) == 0) : 1'b0;
      @(negedge clk);
      k++;
    end
    fullB = 1'b0;
    check("timeout_b", 32'(gotB.size() >= cnt), 32'd1);
  endtask

  initial begin
    rst_n = 1'b0;
    wpA = 8'd0; setA = 1'b0; rpinA = 8'd0; fullA = 1'b0;
    wpB = 8'd2; setB = 1'b0; rpinB = 8'd0; fullB = 1'b0;
    idxA = 0; idxB = 0;
    for (int i = 0; i < 256; i++) begin memA[i] = 8'h00; memB[i] = 8'h00; end
    repeat (2) @(negedge clk);

    // Reset state
    check("rst_rp_a",    32'(rpA), 32'd0);
    check("rst_empty_a", 32'(emptyA), 32'd1);
    check("rst_level_a", 32'(levelA), 32'd0);
    check("rst_enb_a",   32'(enbA), 32'd0);
    check("rst_wren_a",  32'(wrenA), 32'd0);
    check("rst_din_a",   32'(dinA), 32'd0);
    check("rst_rp_b",    32'(rpB), 32'd2);
    check("clk_fwd",     32'({clkbA, fclkB}), 32'({clk, clk}));
    rst_n = 1'b1;
    @(negedge clk);

    // Three words from ring start, spacing and first-write latency
    memA[0] = 8'hA1; memA[1] = 8'hB2; memA[2] = 8'hC3;
    wpA = 8'd3; t0 = cyc;
    #1 check("t1_level", 32'(levelA), 32'd3);
    wait_a(3, 40, 1'b0);
    for (int k = 0; k < 3; k++) begin
      check("t1_data", 32'(gotA[k]), 32'(memA[k]));
      check("t1_time", 32'(gotA_t[k]), 32'(t0 + 3 + 4 * k));
    end
    check("t1_rp",    32'(rpA), 32'd3);
    check("t1_empty", 32'(emptyA), 32'd1);
    check("t1_level0", 32'(levelA), 32'd0);
    idxA = 3; refA = 3;

    // Randomised bursts with optional backpressure
    for (int r = 0; r < 6; r++) begin
      n = $urandom_range(1, 7);
      for (int k = 0; k < n; k++) begin
        expd[k] = 8'($urandom);
        memA[(refA + k) % 8] = expd[k];
      end
      wpA = 8'((refA + n) % 8);
      #1 check("rnd_level_a", 32'(levelA), 32'(n));
      wait_a(idxA + n, 40 * n, r >= 3);
      for (int k = 0; k < n; k++) check("rnd_data_a", 32'(gotA[idxA + k]), 32'(expd[k]));
      idxA += n;
      refA = (refA + n) % 8;
      check("rnd_rp_a", 32'(rpA), 32'(refA));
    end

    // Wrap-around from 6 through 7 to 0
    memA[6] = 8'h11; memA[7] = 8'h22; memA[0] = 8'h33;
    setA = 1'b1; rpinA = 8'd6; wpA = 8'd1;
    @(negedge clk);
    setA = 1'b0;
    check("wrap_rp_load", 32'(rpA), 32'd6);
    check("wrap_level",   32'(levelA), 32'd3);
    wait_a(idxA + 3, 40, 1'b0);
    check("wrap_d0", 32'(gotA[idxA]),     32'h11);
    check("wrap_d1", 32'(gotA[idxA + 1]), 32'h22);
    check("wrap_d2", 32'(gotA[idxA + 2]), 32'h33);
    check("wrap_rp", 32'(rpA), 32'd1);
    idxA += 3;

    // Backpressure held for five Push cycles
    memA[1] = 8'h5A; fullA = 1'b1; wpA = 8'd2;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      check("bp_wren_low", 32'(wrenA), 32'd0);
      check("bp_din_hold", 32'(dinA), 32'h5A);
      @(negedge clk);
    end
    check("bp_no_write", 32'(gotA.size()), 32'(idxA));
    fullA = 1'b0;
    #1 check("bp_wren_high", 32'(wrenA), 32'd1);
    @(negedge clk);
    check("bp_one_write", 32'(gotA.size()), 32'(idxA + 1));
    check("bp_data",      32'(gotA[idxA]), 32'h5A);
    check("bp_wren_drop", 32'(wrenA), 32'd0);
    check("bp_rp",        32'(rpA), 32'd2);
    idxA += 1;

    // Asynchronous reset while stalled in Push
    memA[2] = 8'h77; fullA = 1'b1; wpA = 8'd3;
    repeat (3) @(negedge clk);
    check("rstp_din", 32'(dinA), 32'h77);
    #2 rst_n = 1'b0;
    #1;
    check("rstp_wren",  32'(wrenA), 32'd0);
    check("rstp_enb",   32'(enbA), 32'd0);
    check("rstp_rp",    32'(rpA), 32'd0);
    check("rstp_din0",  32'(dinA), 32'd0);
    check("rstp_level", 32'(levelA), 32'd3);
    wpA = 8'd0; fullA = 1'b0;
    @(negedge clk);
    check("rstp_no_write", 32'(gotA.size()), 32'(idxA));
    rst_n = 1'b1;
    @(negedge clk);
    check("rstp_empty", 32'(emptyA), 32'd1);
    check("rstp_wren2", 32'(wrenA), 32'd0);

    // Clamped pointer loads on ring [2..7]
    setB = 1'b1; rpinB = 8'd9;
    @(negedge clk);
    check("clamp_hi", 32'(rpB), 32'd2);
    rpinB = 8'd1;
    @(negedge clk);
    check("clamp_lo", 32'(rpB), 32'd7);
    for (int k = 0; k < 5; k++) begin
      v = $urandom_range(0, 15);
      e = (v > 7) ? 2 : ((v < 2) ? 7 : v);
      rpinB = 8'(v);
      @(negedge clk);
      check("clamp_rnd", 32'(rpB), 32'(e));
    end
    rpinB = 8'd5; wpB = 8'd5;
    @(negedge clk);
    setB = 1'b0;
    check("b_rp5", 32'(rpB), 32'd5);

    // Two-cycle RAM read, pointer load attempted mid-read
    memB[5] = 8'h3C; enb0 = enbB_cnt; wpB = 8'd6; t0 = cyc;
    @(negedge clk);
    check("rl2_enb_issue", 32'(enbB), 32'd1);
    @(negedge clk);
    setB = 1'b1; rpinB = 8'd2;
    check("rl2_enb_wait",  32'(enbB), 32'd0);
    check("rl2_addr_wait", 32'(addrbB), 32'd5);
    @(negedge clk);
    setB = 1'b0;
    check("rl2_addr_wait2", 32'(addrbB), 32'd5);
    wait_b(1, 20, 1'b0);
    check("rl2_data",    32'(gotB[0]), 32'h3C);
    check("rl2_time",    32'(gotB_t[0]), 32'(t0 + 4));
    check("rl2_enb_cnt", 32'(enbB_cnt - enb0), 32'd1);
    check("rl2_rp",      32'(rpB), 32'd6);
    idxB = 1; refB = 6;

    // Randomised bursts on the offset ring with backpressure
    for (int r = 0; r < 4; r++) begin
      n = $urandom_range(1, 5);
      for (int k = 0; k < n; k++) begin
        expd[k] = 8'($urandom);
        memB[2 + ((refB - 2 + k) % 6)] = expd[k];
      end
      wpB = 8'(2 + ((refB - 2 + n) % 6));
      #1 check("rnd_level_b", 32'(levelB), 32'(n));
      wait_b(idxB + n, 50 * n, r >= 2);
      for (int k = 0; k < n; k++) check("rnd_data_b", 32'(gotB[idxB + k]), 32'(expd[k]));
      idxB += n;
      refB = 2 + ((refB - 2 + n) % 6);
      check("rnd_rp_b", 32'(rpB), 32'(refB));
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
`default_nettype wire
